// File: rtl/load_align_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_align_pkg : access-size encodings and load metadata entry type      |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
package load_align_pkg;

  localparam logic [1:0] LS_BYTE  = 2'd0;
  localparam logic [1:0] LS_HALF  = 2'd1;
  localparam logic [1:0] LS_WORD  = 2'd2;
  localparam logic [1:0] LS_DWORD = 2'd3;

  // Offset is stored at the 64-bit width; narrower builds leave the top bit zero.
  typedef struct packed {
    logic [1:0] size;
    logic       is_unsigned;
    logic [2:0] offset;
  } la_meta_t;

endpackage
`default_nettype wire

// File: rtl/load_align_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_align_queue_if : issue / response / writeback bundle                |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
interface load_align_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int ID_W  = 6
);
  localparam int c_OFF_W = $clog2(XLEN / 8);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [c_OFF_W-1:0]   req_offset;
  logic [ID_W-1:0]      req_rd;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [XLEN-1:0]      rsp_rdata;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [XLEN-1:0]      wb_data;
  logic [ID_W-1:0]      wb_rd;
  logic                 wb_misalign;
  logic                 flush;
  logic [c_CNT_W-1:0]   outstanding;

  modport slave (
    input  req_valid, req_size, req_unsigned, req_offset, req_rd,
    input  rsp_valid, rsp_rdata, wb_ready, flush,
    output req_ready, rsp_ready, wb_valid, wb_data, wb_rd, wb_misalign, outstanding
  );

  modport master (
    output req_valid, req_size, req_unsigned, req_offset, req_rd,
    output rsp_valid, rsp_rdata, wb_ready, flush,
    input  req_ready, rsp_ready, wb_valid, wb_data, wb_rd, wb_misalign, outstanding
  );
endinterface
`default_nettype wire

// File: rtl/load_meta_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_meta_fifo : in-order metadata queue for outstanding loads           |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module load_meta_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  wire logic                         clk,
  input  wire logic                         resetn,
  input  wire logic                         clear,
  input  wire logic                         push,
  input  wire logic [WIDTH-1:0]             push_data,
  input  wire logic                         pop,
  output logic [WIDTH-1:0]                  head,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              full,
  output logic                              empty
);
  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= f_next(r_wr_ptr);
      if (pop)  r_rd_ptr <= f_next(r_rd_ptr);
      r_count <= r_count + c_CNT_W'(push) - c_CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == c_CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/load_align_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_align_queue : in-order load response aligner / sign extender        |
// | Optional: LOAD_ALIGN_MISALIGN_TRAP_EN flags misaligned accesses          |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module load_align_queue
  import load_align_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int ID_W  = 6
) (
  input  wire logic           clk,
  input  wire logic           resetn,
  load_align_queue_if.slave   bus
);
  localparam int c_OFF_W   = $clog2(XLEN / 8);
  localparam int c_CNT_W   = $clog2(DEPTH) + 1;
  localparam int c_IDX_W   = $clog2(XLEN);
  localparam int c_ENTRY_W = $bits(la_meta_t) + ID_W;
  localparam int c_DROP_W  = 8;

  la_meta_t               w_meta_in;
  la_meta_t               w_head_meta;
  logic [c_ENTRY_W-1:0]   w_head;
  logic [ID_W-1:0]        w_head_rd;
  logic [c_CNT_W-1:0]     w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_has_drop;
  logic                   w_rsp_hs;
  logic                   w_pop;
  logic [1:0]             w_size;
  logic [2:0]             w_low_mask;
  logic [2:0]             w_off;
  logic [6:0]             w_bits;
  logic [XLEN-1:0]        w_shifted;
  logic [XLEN-1:0]        w_mask;
  logic                   w_sign;
  logic [XLEN-1:0]        w_aligned;
  logic [XLEN-1:0]        w_wb_data;
  logic                   w_wb_mis;
  logic [c_DROP_W-1:0]    r_drop_cnt;
  logic                   r_wb_valid;
  logic [XLEN-1:0]        r_wb_data;
  logic [ID_W-1:0]        r_wb_rd;
  logic                   r_wb_misalign;

  always_comb begin
    w_meta_in                      = '0;
    w_meta_in.size                 = bus.req_size;
    w_meta_in.is_unsigned          = bus.req_unsigned;
    w_meta_in.offset[c_OFF_W-1:0]  = bus.req_offset;
  end

  load_meta_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_meta_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (bus.flush),
    .push      (bus.req_valid && bus.req_ready),
    .push_data ({w_meta_in, bus.req_rd}),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign w_head_meta = la_meta_t'(w_head[c_ENTRY_W-1:ID_W]);
  assign w_head_rd   = w_head[ID_W-1:0];

  assign w_has_drop      = (r_drop_cnt != '0);
  assign bus.req_ready   = !w_full && !bus.flush;
  assign bus.rsp_ready   = (!w_empty || w_has_drop) && (!r_wb_valid || bus.wb_ready);
  assign w_rsp_hs        = bus.rsp_valid && bus.rsp_ready;
  // Responses belonging to flushed loads are older than anything queued, so they drain first.
  assign w_pop           = w_rsp_hs && !w_has_drop;

  always_comb begin
    w_size = w_head_meta.size;
    if (XLEN == 32 && w_size == LS_DWORD) w_size = LS_WORD;
    case (w_size)
      LS_BYTE: w_low_mask = 3'b000;
      LS_HALF: w_low_mask = 3'b001;
      LS_WORD: w_low_mask = 3'b011;
      default: w_low_mask = 3'b111;
    endcase
`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
    w_off = w_head_meta.offset;
`else
    w_off = w_head_meta.offset & ~w_low_mask;
`endif
    w_bits    = 7'd8 << w_size;
    w_shifted = bus.rsp_rdata >> {w_off, 3'b000};
    // A full-width access shifts every one out, leaving an all-ones mask.
    w_mask    = ~({XLEN{1'b1}} << w_bits);
    w_sign    = !w_head_meta.is_unsigned && w_shifted[c_IDX_W'(w_bits - 7'd1)];
    w_aligned = (w_shifted & w_mask) | ({XLEN{w_sign}} & ~w_mask);
  end

`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
  assign w_wb_mis  = |(w_head_meta.offset & w_low_mask);
  assign w_wb_data = w_wb_mis ? '0 : w_aligned;
`else
  assign w_wb_mis  = 1'b0;
  assign w_wb_data = w_aligned;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_drop_cnt <= '0;
    end else if (bus.flush) begin
      r_drop_cnt <= r_drop_cnt + c_DROP_W'(w_count) - c_DROP_W'(w_rsp_hs);
    end else if (w_rsp_hs && w_has_drop) begin
      r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wb_valid    <= 1'b0;
      r_wb_data     <= '0;
      r_wb_rd       <= '0;
      r_wb_misalign <= 1'b0;
    end else if (bus.flush) begin
      r_wb_valid    <= 1'b0;
    end else if (w_pop) begin
      r_wb_valid    <= 1'b1;
      r_wb_data     <= w_wb_data;
      r_wb_rd       <= w_head_rd;
      r_wb_misalign <= w_wb_mis;
    end else if (bus.wb_ready) begin
      r_wb_valid    <= 1'b0;
    end
  end

  assign bus.wb_valid    = r_wb_valid;
  assign bus.wb_data     = r_wb_data;
  assign bus.wb_rd       = r_wb_rd;
  assign bus.wb_misalign = r_wb_misalign;
  assign bus.outstanding = w_count;

endmodule
`default_nettype wire

// File: tb/tb_load_align_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_load_align_queue : directed + random check against a queue model      |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
module tb_load_align_queue;
  localparam int DEPTH = 4;
  localparam int ID_W  = 6;

  logic clk;
  logic resetn;

  load_align_queue_if #(.XLEN(32), .DEPTH(DEPTH), .ID_W(ID_W)) bus ();
  load_align_queue_if #(.XLEN(64), .DEPTH(DEPTH), .ID_W(ID_W)) b64 ();

  load_align_queue #(.XLEN(32), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk (clk), .resetn (resetn), .bus (bus.slave)
  );
  load_align_queue #(.XLEN(64), .DEPTH(DEPTH), .ID_W(ID_W)) dut64 (
    .clk (clk), .resetn (resetn), .bus (b64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int size;
    bit uns;
    int off;
    int rd;
  } ld_t;

  ld_t         q[$];
  int          drop;
  bit          m_wbv;
  logic [63:0] m_data;
  int          m_rd;
  bit          m_mis;
  int          vectors;
  int          errors;

  function automatic logic [63:0] align_ref(input int xlen, input int size, input bit uns,
                                            input int off, input logic [63:0] rdata,
                                            output bit mis);
    int nb;
    int o;
    logic [63:0] v;
    if (xlen == 32 && size == 3) size = 2;
    nb  = 1 << size;
    mis = 1'b0;
    o   = off;
    if (off % nb != 0) begin
`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
      mis = 1'b1;
      return 64'd0;
`else
      o = off - (off % nb);
`endif
    end
    v = '0;
    for (int b = 0; b < nb; b++) v[8*b +: 8] = rdata[8*(o+b) +: 8];
    if (!uns && v[8*nb-1]) begin
      for (int i = 8*nb; i < xlen; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    drop  = 0;
    m_wbv = 1'b0;
  endtask

  // One clock of stimulus: drive, check against the model, clock, advance the model.
  task automatic step(input bit rv, input int sz, input bit un, input int off, input int rd,
                      input bit sv, input logic [31:0] rdata, input bit wr, input bit fl);
    bit exp_rq, exp_sr, rq_hs, rs_hs, wb_hs, mis;
    logic [63:0] d;
    ld_t e;
    bus.req_valid    = rv;
    bus.req_size     = 2'(sz);
    bus.req_unsigned = un;
    bus.req_offset   = 2'(off);
    bus.req_rd       = 6'(rd);
    bus.rsp_valid    = sv;
    bus.rsp_rdata    = rdata;
    bus.wb_ready     = wr;
    bus.flush        = fl;
    #1;
    exp_rq = (q.size() < DEPTH) && !fl;
    exp_sr = (q.size() > 0 || drop > 0) && (!m_wbv || wr);
    chk("req_ready", bus.req_ready, exp_rq);
    chk("rsp_ready", bus.rsp_ready, exp_sr);
    chk("outstanding", bus.outstanding, q.size());
    chk("wb_valid", bus.wb_valid, m_wbv);
    if (m_wbv) begin
      chk("wb_data", bus.wb_data, m_data);
      chk("wb_rd", bus.wb_rd, m_rd);
      chk("wb_misalign", bus.wb_misalign, m_mis);
    end
    rq_hs = rv && exp_rq;
    rs_hs = sv && exp_sr;
    wb_hs = m_wbv && wr;
    @(posedge clk);
    #1;
    if (wb_hs) m_wbv = 1'b0;
    if (rs_hs) begin
      if (drop > 0) begin
        drop--;
      end else begin
        e = q.pop_front();
        d = align_ref(32, e.size, e.uns, e.off, {32'd0, rdata}, mis);
        m_wbv  = 1'b1;
        m_data = d;
        m_rd   = e.rd;
        m_mis  = mis;
      end
    end
    if (fl) begin
      drop += q.size();
      q.delete();
      m_wbv = 1'b0;
    end
    if (rq_hs) q.push_back('{size: sz, uns: un, off: off, rd: rd});
  endtask

  task automatic push(input int sz, input bit un, input int off, input int rd);
    step(1'b1, sz, un, off, rd, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic resp(input logic [31:0] rdata, input bit wr);
    step(1'b0, 0, 1'b0, 0, 0, 1'b1, rdata, wr, 1'b0);
  endtask

  task automatic run64(input string tag, input int sz, input bit un, input int off,
                       input logic [63:0] rdata, input int rd);
    bit mis;
    logic [63:0] exp;
    exp = align_ref(64, sz, un, off, rdata, mis);
    b64.req_valid    = 1'b1;
    b64.req_size     = 2'(sz);
    b64.req_unsigned = un;
    b64.req_offset   = 3'(off);
    b64.req_rd       = 6'(rd);
    #1 chk({tag, "_req_ready"}, b64.req_ready, 1);
    @(posedge clk); #1;
    b64.req_valid = 1'b0;
    b64.rsp_valid = 1'b1;
    b64.rsp_rdata = rdata;
    #1 chk({tag, "_rsp_ready"}, b64.rsp_ready, 1);
    @(posedge clk); #1;
    b64.rsp_valid = 1'b0;
    chk({tag, "_valid"}, b64.wb_valid, 1);
    chk({tag, "_data"}, b64.wb_data, exp);
    chk({tag, "_rd"}, b64.wb_rd, rd);
    chk({tag, "_mis"}, b64.wb_misalign, mis);
    @(posedge clk); #1;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    model_reset();
    resetn = 1'b0;
    bus.req_valid = 1'b0; bus.req_size = '0; bus.req_unsigned = 1'b0; bus.req_offset = '0;
    bus.req_rd = '0; bus.rsp_valid = 1'b0; bus.rsp_rdata = '0; bus.wb_ready = 1'b1; bus.flush = 1'b0;
    b64.req_valid = 1'b0; b64.req_size = '0; b64.req_unsigned = 1'b0; b64.req_offset = '0;
    b64.req_rd = '0; b64.rsp_valid = 1'b0; b64.rsp_rdata = '0; b64.wb_ready = 1'b1; b64.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    // Reset state, and a response with nothing outstanding is refused.
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_wb_mis", bus.wb_misalign, 0);
    resp(32'h1234_5678, 1'b1);

    // Signed byte at offset 3.
    push(0, 1'b0, 3, 5);
    resp(32'h80FF_1234, 1'b1);
    chk("b031_data", bus.wb_data, 32'hFFFF_FF80);
    chk("b031_rd", bus.wb_rd, 5);
    step(1'b0, 0, 1'b0, 0, 0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Fill to DEPTH; a pop with a held request refills the freed slot one cycle later.
    for (int i = 0; i < DEPTH; i++) push(2, 1'b1, 0, 30 + i);
    chk("full_outstanding", bus.outstanding, DEPTH);
    chk("full_req_ready", bus.req_ready, 0);
    step(1'b1, 1, 1'b1, 2, 40, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step(1'b1, 1, 1'b1, 2, 40, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("refill_outstanding", bus.outstanding, DEPTH);
    for (int i = 0; i < DEPTH; i++) resp($urandom, 1'b1);
    step(1'b0, 0, 1'b0, 0, 0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Flush with three outstanding; their responses are swallowed.
    for (int i = 0; i < 3; i++) push(0, 1'b1, i, 10 + i);
    step(1'b0, 0, 1'b0, 0, 0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("flush_outstanding", bus.outstanding, 0);
    chk("flush_rsp_ready", bus.rsp_ready, 1);
    push(2, 1'b1, 0, 20);
    for (int i = 0; i < 3; i++) resp($urandom, 1'b1);
    chk("drop_no_wb", bus.wb_valid, 0);
    resp(32'hCAFE_F00D, 1'b1);
    chk("after_drop_valid", bus.wb_valid, 1);
    chk("after_drop_rd", bus.wb_rd, 20);
    chk("after_drop_data", bus.wb_data, 32'hCAFE_F00D);
    step(1'b0, 0, 1'b0, 0, 0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Writeback back-pressure holds the result and stalls responses.
    push(2, 1'b1, 0, 1);
    push(0, 1'b1, 2, 2);
    resp(32'h1122_3344, 1'b0);
    for (int i = 0; i < 5; i++) resp(32'h00AB_0000, 1'b0);
    chk("stall_data", bus.wb_data, 32'h1122_3344);
    chk("stall_rd", bus.wb_rd, 1);
    resp(32'h00AB_0000, 1'b1);
    chk("stall_next_data", bus.wb_data, 32'h0000_00AB);
    chk("stall_next_rd", bus.wb_rd, 2);
    step(1'b0, 0, 1'b0, 0, 0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Half-word at an odd offset.
    push(1, 1'b0, 1, 9);
    resp(32'hAABB_CCDD, 1'b1);
`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
    chk("half_off1_mis", bus.wb_misalign, 1);
    chk("half_off1_data", bus.wb_data, 32'h0000_0000);
`else
    chk("half_off1_mis", bus.wb_misalign, 0);
    chk("half_off1_data", bus.wb_data, 32'hFFFF_CCDD);
`endif
    step(1'b0, 0, 1'b0, 0, 0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Reset in the middle of traffic discards everything.
    push(2, 1'b0, 0, 3);
    push(2, 1'b0, 0, 4);
    resp(32'h8765_4321, 1'b0);
    resetn = 1'b0;
    #1;
    chk("midrst_wb_valid", bus.wb_valid, 0);
    chk("midrst_wb_data", bus.wb_data, 0);
    chk("midrst_outstanding", bus.outstanding, 0);
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) resp($urandom, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 2) == 0, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3), $urandom_range(0, 63), ($urandom % 2) == 0, $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
    end

    // 64-bit datapath.
    run64("w64", 2, 1'b1, 4, 64'h8000_0001_0000_0000, 7);
    chk("w64_const", b64.wb_data, 64'h0000_0000_8000_0001);
    run64("b64", 0, 1'b0, 7, 64'h9A00_0000_0000_0000, 8);
    run64("d64", 3, 1'b0, 0, 64'hF123_4567_89AB_CDEF, 9);
    run64("ws64", 2, 1'b0, 0, 64'h0000_0000_8000_0002, 10);
    run64("hm64", 1, 1'b1, 3, 64'h1122_3344_5566_7788, 11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
